// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, widths and sequence-state type shared by the seven-segment stream decoder.
package seg7_pkg;
  localparam int SEG_W = 7;
  localparam int DIG_W = 4;
  localparam int ERR_W = 8;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  typedef enum logic {ACQUIRE, LOCKED} seq_state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational map from a segment pattern to a hex digit below MODULUS, or blank.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int MODULUS = 16
) (
  input  logic [SEG_W-1:0] pattern,
  output logic             is_digit,
  output logic             is_blank,
  output logic [DIG_W-1:0] value
);
  always_comb begin
    is_digit = 1'b0;
    value    = '0;
    for (int i = 0; i < MODULUS; i++)
      if (pattern == SEG_CODES[i]) begin
        is_digit = 1'b1;
        value    = DIG_W'(i);
      end
  end
  assign is_blank = pattern == SEG_BLANK;
endmodule

// File: rtl/seg7_stream_decoder.sv
// seg7_stream_decoder: synchronises and stability-filters a strobe-less 7-segment bus,
// decodes accepted patterns and checks they follow a modulo count sequence.
module seg7_stream_decoder
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int MODULUS       = 16,
  parameter int LOCK_COUNT    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] seg_in,
  input  logic             enable,
  output logic [DIG_W-1:0] digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);
  logic [SYNC_STAGES-1:0][SEG_W-1:0] sync;
  logic [SEG_W-1:0] s, s_prev, last_acc;
  logic [3:0] stab_cnt, run;
  logic [DIG_W-1:0] value, expected;
  logic is_digit, is_blank, accept;
  seq_state_t state;
  assign s = sync[SYNC_STAGES-1];
  // accept on the cycle the counter would first hit STABLE_CYCLES
  assign accept = enable && s == s_prev && stab_cnt == 4'(STABLE_CYCLES - 1) && s != last_acc;
  seg7_decode #(.MODULUS(MODULUS)) u_decode (
    .pattern (s),
    .is_digit(is_digit),
    .is_blank(is_blank),
    .value   (value)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      s_prev   <= '0;
      stab_cnt <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], seg_in};
      s_prev   <= s;
      stab_cnt <= s != s_prev ? 4'd0 : stab_cnt == 4'(STABLE_CYCLES) ? stab_cnt : stab_cnt + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_acc    <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      blank       <= 1'b1;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
      state       <= ACQUIRE;
      expected    <= '0;
      run         <= '0;
    end else begin
      digit_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      if (accept) begin
        last_acc <= s;
        if (is_blank) begin
          blank <= 1'b1;
        end else if (!is_digit) begin
          illegal   <= 1'b1;
          err_count <= err_count + ERR_W'(~&err_count);
          state     <= ACQUIRE;
          locked    <= 1'b0;
          run       <= '0;
        end else begin
          digit       <= value;
          digit_valid <= 1'b1;
          blank       <= 1'b0;
          expected    <= value == DIG_W'(MODULUS - 1) ? '0 : value + 4'd1;
          if (state == LOCKED) begin
            if (value != expected) begin
              seq_err   <= 1'b1;
              err_count <= err_count + ERR_W'(~&err_count);
              state     <= ACQUIRE;
              locked    <= 1'b0;
              run       <= 4'd1;
            end
          end else if (value == expected && run != 0) begin
            // run counts the anchor digit, so LOCK_COUNT in-sequence digits follow it
            run <= run + 4'd1;
            if (run >= 4'(LOCK_COUNT)) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else begin
            run <= 4'd1;
          end
        end
      end
    end
  end
endmodule

// File: doc/seg7_stream_decoder.md
Name: seg7_stream_decoder

Overview:
- Receive-side companion to the counter-driven seven-segment pattern generators in the user-module set.
- Watches a free-running 7-segment bus that carries no strobe and filters it for stability.
- Decodes each accepted pattern to a hex digit and checks that successive digits follow the expected count sequence.
- Reports lock status, sequence errors and illegal patterns, so a generator can be verified on silicon by looping its outputs back.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on seg_in; legal range 2..3.
- STABLE_CYCLES, 4: clocks the synchronised pattern must hold unchanged before it is accepted; legal range 1..15.
- MODULUS, 16: sequence wraps from MODULUS-1 to 0; legal range 2..16.
- LOCK_COUNT, 3: consecutive in-sequence digits required to declare lock; legal range 1..7.

Ports:
- clk, input, 1: single clock for the whole block.
- rst_n, input, 1: asynchronous, active-low reset.
- seg_in, input, 7: segments a..g on bits 0..6, asynchronous to clk.
- enable, input, 1: when low, no symbol is accepted; the filter keeps running.
- digit, output, 4: last accepted digit value.
- digit_valid, output, 1: one-cycle pulse per accepted digit.
- blank, output, 1: level; high while the last accepted pattern was 7'h00.
- illegal, output, 1: one-cycle pulse when a non-hex, non-blank pattern is accepted.
- seq_err, output, 1: one-cycle pulse when a digit breaks the sequence while LOCKED.
- locked, output, 1: level; high in LOCKED state.
- err_count, output, 8: count of seq_err plus illegal events; saturates at 8'hFF.

Behaviour:
- Reset values: digit=0, digit_valid=0, blank=1, illegal=0, seq_err=0, locked=0, err_count=0. State is ACQUIRE, expected=0, run=0. The synchroniser, stability counter and last-accepted pattern all clear to 0.
- Synchroniser: each seg_in bit passes through SYNC_STAGES flops to give s.
- Stability filter:
  - stab_cnt clears to 0 in any cycle where s differs from the previous s. Otherwise it increments, saturating at STABLE_CYCLES.
  - A pattern is accepted in the cycle stab_cnt first reaches STABLE_CYCLES, provided enable=1 and s differs from last_acc.
  - On acceptance, last_acc <= s.
  - A pattern that reappears after a glitch is not re-accepted; only a change of pattern produces a new symbol.
- Latency: seg_in held stable after a change gives digit_valid exactly SYNC_STAGES+STABLE_CYCLES+1 clock edges later. All outputs are registered.
- Decode, hex a..g codes: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. 00 is blank. Every other code is illegal.
  - Digit codes with value >= MODULUS are treated as illegal.
  - Blank: sets blank=1. No digit_valid, no state change, no error.
  - Illegal: illegal pulse, err_count+1. LOCKED goes to ACQUIRE with run=0. digit is unchanged.
  - Digit d: digit<=d, digit_valid pulse, blank<=0, then apply the sequence FSM below.
- Sequence FSM, states ACQUIRE and LOCKED:
  - ACQUIRE, d==expected and run>0: run+1. When run reaches LOCK_COUNT, go to LOCKED.
  - ACQUIRE, otherwise: run<=1. No error is raised in ACQUIRE.
  - LOCKED, d==expected: stay in LOCKED.
  - LOCKED, d!=expected: seq_err pulse, err_count+1, go to ACQUIRE with run=1.
  - In every case, expected <= (d+1) mod MODULUS.
- Wrap: with MODULUS=10, the digit following 9 is 0. The codes A..F are illegal.
- Coincident events: illegal and seq_err never pulse in the same cycle. err_count increments by at most 1 per cycle.
- Saturation: err_count holds at FF. Pulses still fire.
- enable low: freezes the FSM and accepted state. When enable rises, the next stable-count completion on a differing pattern is accepted normally.
- Reset mid-operation: all state clears immediately. The first digit accepted after reset starts ACQUIRE.

Decomposition:
- Package seg7_pkg:
  - 16-entry segment code constants and SEG_BLANK.
  - seq_state_t enum {ACQUIRE, LOCKED}.
  - Width constants: SEG_W=7, DIG_W=4, ERR_W=8.
- Sub-module seg7_decode: purely combinational. Inputs: 7-bit pattern and MODULUS. Outputs: is_digit, is_blank, value[3:0].
- Synchroniser, filter, FSM and counter stay in the top module.

Test Plan (defaults, latency 7):
- After reset, drive 3F,06,5B,4F, each held 10 clocks.
  - Expect four digit_valid pulses with digit 0,1,2,3.
  - locked rises with digit 3: run reaches 3 on that digit.
  - err_count stays 0.
- From LOCKED on digit 3, drive 6D (digit 5).
  - Expect a seq_err pulse, err_count=1, locked=0, digit=5.
  - Then 7D,07,7F gives locked=1 again on 7F.
- Drive 3F, glitch to 06 for 2 clocks, return to 3F. Expect no digit_valid for either the glitch or the return.
- MODULUS=10: sequence 8,9,0 stays locked. Then pattern 77 ('A') gives an illegal pulse, err_count+1 and locked=0.
- Blank 00 inserted between 2 and 3 while LOCKED: blank=1, no error, lock held, then 4F gives digit 3 with blank=0.
- Force 300 alternating illegal patterns: err_count saturates at FF. Assert rst_n low mid-hold: all outputs return to reset values asynchronously.
